// File: rtl/xdma_pkg.sv
// Shared definitions for the XDMA C2H stream path: AXIS widths, the arbiter state type and a
// round-robin index helper.
package xdma_pkg;

  localparam int unsigned AXIS_DATA_W = 512;
  localparam int unsigned AXIS_KEEP_W = AXIS_DATA_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Next index in a ring of n entries, wrapping n-1 -> 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream output slice. Every output, including in_ready, comes straight from a
// flop, so downstream backpressure never reaches the requesters combinationally.
module axis_skid_buffer
  import xdma_pkg::*;
#(
  parameter int unsigned DATA_W = AXIS_DATA_W,
  parameter int unsigned ID_W   = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [DATA_W/8-1:0] in_keep,
  input  logic                in_last,
  input  logic [ID_W-1:0]     in_id,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [DATA_W/8-1:0] out_keep,
  output logic                out_last,
  output logic [ID_W-1:0]     out_id,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int unsigned BEAT_W = DATA_W + DATA_W / 8 + 1 + ID_W;

  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] out_beat_q, out_beat_d;
  logic [BEAT_W-1:0] skid_beat_q, skid_beat_d;
  logic [1:0]        count_q, count_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              push, pop;

  assign in_beat = {in_data, in_keep, in_last, in_id};
  assign push    = in_valid && ready_q;
  assign pop     = valid_q && out_ready;

  // out_beat is the head entry, skid_beat the second; the head is what m_axis shows.
  always_comb begin
    count_d     = count_q;
    out_beat_d  = out_beat_q;
    skid_beat_d = skid_beat_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          out_beat_d = in_beat;
          count_d    = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          out_beat_d = in_beat;
        end else if (push) begin
          skid_beat_d = in_beat;
          count_d     = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          out_beat_d = skid_beat_q;
          count_d    = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
    valid_d = (count_d != 2'd0);
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_beat_q  <= '0;
      skid_beat_q <= '0;
      count_q     <= 2'd0;
      valid_q     <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      out_beat_q  <= out_beat_d;
      skid_beat_q <= skid_beat_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      ready_q     <= ready_d;
    end
  end

  assign {out_data, out_keep, out_last, out_id} = out_beat_q;
  assign out_valid = valid_q;
  assign in_ready  = ready_q;

endmodule

// File: rtl/xdma_axis_arbiter.sv
// Packet-granular round-robin arbiter sharing one XDMA C2H AXI-Stream channel between N_SRC
// packetisers; whole packets are never interleaved and the output is a registered slice.
module xdma_axis_arbiter
  import xdma_pkg::*;
#(
  parameter int unsigned N_SRC  = 2,
  parameter int unsigned DATA_W = AXIS_DATA_W,
  parameter int unsigned ID_W   = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [N_SRC*DATA_W-1:0]   s_axis_tdata,
  input  logic [N_SRC*DATA_W/8-1:0] s_axis_tkeep,
  input  logic [N_SRC-1:0]          s_axis_tlast,
  input  logic [N_SRC-1:0]          s_axis_tvalid,
  output logic [N_SRC-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic [DATA_W/8-1:0]       m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [ID_W-1:0]           m_axis_tid,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      busy
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned PTR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]  pick;
  logic              found;
  int unsigned       idx;

  logic              slice_ready;
  logic              beat_valid;
  logic              beat_fire;
  logic [DATA_W-1:0] beat_data;
  logic [KEEP_W-1:0] beat_keep;
  logic              beat_last;

  // Search starts just after the last winner, so that winner has lowest priority.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    idx   = rr_next(32'(rr_ptr_q), N_SRC);
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!found && s_axis_tvalid[idx]) begin
        found = 1'b1;
        pick  = PTR_W'(idx);
      end
      idx = rr_next(idx, N_SRC);
    end
  end

  assign beat_data  = s_axis_tdata[32'(grant_q) * DATA_W +: DATA_W];
  assign beat_keep  = s_axis_tkeep[32'(grant_q) * KEEP_W +: KEEP_W];
  assign beat_last  = s_axis_tlast[grant_q];
  assign beat_valid = (state_q == BUSY) && s_axis_tvalid[grant_q];
  assign beat_fire  = beat_valid && slice_ready;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d  = pick;
          rr_ptr_d = pick;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // A source that stalls mid-packet keeps the grant until it delivers tlast.
        if (beat_fire && beat_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PTR_W'(N_SRC - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Ready is built only from flops (state, grant, slice ready), never from tvalid.
  always_comb begin
    s_axis_tready = '0;
    if (state_q == BUSY) begin
      s_axis_tready[grant_q] = slice_ready;
    end
  end

  assign busy = (state_q == BUSY);

  axis_skid_buffer #(
    .DATA_W (DATA_W),
    .ID_W   (ID_W)
  ) u_slice (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (beat_data),
    .in_keep   (beat_keep),
    .in_last   (beat_last),
    .in_id     (ID_W'(grant_q)),
    .in_valid  (beat_valid),
    .in_ready  (slice_ready),
    .out_data  (m_axis_tdata),
    .out_keep  (m_axis_tkeep),
    .out_last  (m_axis_tlast),
    .out_id    (m_axis_tid),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

endmodule

// File: tb/tb_xdma_axis_arbiter.sv
// Scoreboard bench for xdma_axis_arbiter: per-source expected-beat queues plus an expected
// packet-order queue, checked by a monitor decoupled from the stimulus drivers.
module tb_xdma_axis_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned IW = 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic            clock;
  logic            reset_n;
  wire  [N*DW-1:0] s_tdata;
  wire  [N*KW-1:0] s_tkeep;
  wire  [N-1:0]    s_tlast;
  wire  [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tlast;
  logic [IW-1:0]   m_tid;
  logic            m_tvalid;
  logic            m_tready;
  logic            busy;

  logic [DW-1:0] src_data  [N];
  logic [KW-1:0] src_keep  [N];
  logic          src_last  [N];
  logic          src_valid [N];
  logic          acc       [N];
  int            drop      [N];

  beat_t tx_q  [N][$];
  beat_t exp_q [N][$];
  int    exp_order[$];

  int    n_cmp = 0;
  int    n_fail = 0;
  int    gap_pct = 0;
  bit    ready_rand = 0;
  int    ready_pct = 70;

  bit            in_pkt;
  int            cur_src;
  bit            stall_prev;
  logic [DW-1:0] prev_data;
  logic [KW+IW:0] prev_ctl;

  xdma_axis_arbiter #(
    .N_SRC  (N),
    .DATA_W (DW),
    .ID_W   (IW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-source drivers: hold a beat until accepted, optional random gaps, forced drops.
  for (genvar g = 0; g < N; g++) begin : g_src
    assign s_tdata[g*DW +: DW] = src_data[g];
    assign s_tkeep[g*KW +: KW] = src_keep[g];
    assign s_tlast[g]          = src_last[g];
    assign s_tvalid[g]         = src_valid[g];

    always @(negedge clock) acc[g] = src_valid[g] && s_tready[g] && reset_n;

    initial begin
      bit hold;
      src_valid[g] = 1'b0;
      src_data[g]  = '0;
      src_keep[g]  = '0;
      src_last[g]  = 1'b0;
      drop[g]      = 0;
      forever begin
        @(posedge clock);
        #1;
        hold = src_valid[g] && !acc[g];
        if (acc[g] && tx_q[g].size() > 0) tx_q[g].delete(0);
        acc[g] = 1'b0;
        if (drop[g] > 0) begin
          drop[g]--;
          src_valid[g] = 1'b0;
        end else if (tx_q[g].size() == 0) begin
          src_valid[g] = 1'b0;
        end else if (hold || $urandom_range(99) >= gap_pct) begin
          src_valid[g] = 1'b1;
          src_data[g]  = tx_q[g][0].data;
          src_keep[g]  = tx_q[g][0].keep;
          src_last[g]  = tx_q[g][0].last;
        end else begin
          src_valid[g] = 1'b0;
        end
      end
    end
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (ready_rand) m_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor: pops the scoreboard whenever a beat leaves on m_axis.
  always @(negedge clock) begin
    if (reset_n) begin
      check("ready_onehot0", 640'($countones(s_tready) <= 1), 640'(1));
      if (m_tvalid) begin
        if (stall_prev) begin
          check("hold_data", 640'(m_tdata), 640'(prev_data));
          check("hold_ctl", 640'({m_tkeep, m_tlast, m_tid}), 640'(prev_ctl));
        end
        if (m_tready) begin
          int s;
          beat_t e;
          s = int'(m_tid);
          if (in_pkt) check("no_interleave", 640'(s), 640'(cur_src));
          else begin
            if (exp_order.size() > 0) check("arb_order", 640'(s), 640'(exp_order.pop_front()));
            cur_src = s;
            in_pkt  = 1'b1;
          end
          if (exp_q[s].size() == 0) begin
            check("unexpected_beat", 640'(s), 640'(N));
          end else begin
            e = exp_q[s].pop_front();
            check("beat_data", 640'(m_tdata), 640'(e.data));
            check("beat_ctl", 640'({m_tkeep, m_tlast}), 640'({e.keep, e.last}));
          end
          if (m_tlast) in_pkt = 1'b0;
        end
      end
      stall_prev = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_ctl   = {m_tkeep, m_tlast, m_tid};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_pkt(input int s, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < DW / 32; w++) b.data[w*32 +: 32] = $urandom;
      b.keep = {$urandom, $urandom};
      b.last = (i == len - 1);
      tx_q[s].push_back(b);
      exp_q[s].push_back(b);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < N; s++) begin
      tx_q[s].delete();
      exp_q[s].delete();
      src_valid[s] = 1'b0;
      acc[s]       = 1'b0;
      drop[s]      = 0;
    end
    exp_order.delete();
    in_pkt     = 1'b0;
    stall_prev = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clock);
      done = (tx_q[0].size() == 0) && (tx_q[1].size() == 0) && (exp_q[0].size() == 0) &&
             (exp_q[1].size() == 0) && !m_tvalid;
    end
    check("drain_done", 640'(done), 640'(1));
    check("order_consumed", 640'(exp_order.size()), 640'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    clear_model();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // 1: idle after reset
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      check("idle_outputs", 640'({s_tready, m_tvalid, busy}), 640'(0));
    end

    // 2: single 4-beat packet from src0, cycle-exact timing
    exp_order.push_back(0);
    push_pkt(0, 4);
    @(posedge clock);
    for (int c = 0; c <= 6; c++) begin
      @(negedge clock);
      if (c == 1) check("t2_busy_c1", 640'(busy), 640'(1));
      if (c == 6) check("t2_busy_c6", 640'(busy), 640'(0));
      check("t2_mvalid", 640'(m_tvalid), 640'(c >= 2 && c <= 5));
      if (m_tvalid) check("t2_mlast", 640'(m_tlast), 640'(c == 5));
    end
    wait_drain(50);

    // 3: both sources backlogged with 3-beat packets -> alternation starting at src1
    for (int p = 0; p < 4; p++) begin
      push_pkt(0, 3);
      push_pkt(1, 3);
      exp_order.push_back(1);
      exp_order.push_back(0);
    end
    wait_drain(200);

    // 4: output stalled for 5 cycles mid-packet
    exp_order.push_back(0);
    push_pkt(0, 10);
    @(posedge clock);
    repeat (4) @(posedge clock);
    #1 m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      if (k >= 1) check("t4_sready_full", 640'(s_tready), 640'(0));
    end
    @(posedge clock);
    #1 m_tready = 1'b1;
    wait_drain(100);

    // 5: granted source drops tvalid while the other waits
    exp_order.push_back(0);
    exp_order.push_back(1);
    push_pkt(0, 6);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    drop[0] = 3;
    push_pkt(1, 3);
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("t5_held", 640'({busy, s_tready[1]}), 640'(2'b10));
    end
    wait_drain(100);

    // Randomised traffic with gaps and backpressure
    gap_pct    = 30;
    ready_rand = 1'b1;
    for (int p = 0; p < 15; p++) begin
      push_pkt(0, int'($urandom_range(5, 1)));
      push_pkt(1, int'($urandom_range(5, 1)));
    end
    wait_drain(3000);
    ready_rand = 1'b0;
    gap_pct    = 0;
    @(posedge clock);
    #1 m_tready = 1'b1;

    // 6: reset mid-packet
    push_pkt(0, 8);
    push_pkt(1, 8);
    repeat (4) @(negedge clock);
    reset_n = 1'b0;
    clear_model();
    #1;
    check("t6_rst_async", 640'({s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, busy}),
          640'(0));
    @(negedge clock);
    check("t6_rst_cycle", 640'({s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, busy}),
          640'(0));
    reset_n = 1'b1;
    exp_order.push_back(0);
    exp_order.push_back(1);
    push_pkt(0, 2);
    push_pkt(1, 2);
    wait_drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
